// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared declarations for the loadable countdown timer.
//   state_t : controller state. IDLE accepts loads; RUN counts down.
package countdown_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : countdown_pkg

// File: rtl/countdown_timer.sv
// countdown_timer
// Loadable down-counter with a one-cycle terminal pulse. It supports
// one-shot or periodic (auto-reload) operation.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous, active-low reset
//   i_load_valid   load request (held by producer until o_load_ready)
//   o_load_ready   high while IDLE
//   i_load_val     start value N, sampled on handshake
//   i_auto_reload  periodic mode, sampled on handshake
//   i_en           decrement enable, honoured only in RUN
//   i_abort        cancel a running countdown, honoured only in RUN
//   o_cnt          current count (registered)
//   o_busy         high while RUN
//   o_tc           registered one-cycle expiry pulse
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_auto_reload,
    input  logic             i_en,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] cnt_reg,    cnt_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             flag_reg,   flag_next;
    logic             tc_reg,     tc_next;

    // All state lives in this single register block. The next values are
    // computed below.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= CNT_ZERO;
            reload_reg <= CNT_ZERO;
            flag_reg   <= 1'b0;
            tc_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            reload_reg <= reload_next;
            flag_reg   <= flag_next;
            tc_reg     <= tc_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        reload_next = reload_reg;
        flag_next   = flag_reg;
        tc_next     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // i_en and i_abort are ignored here. A load always wins.
                if (i_load_valid) begin
                    if (i_load_val != CNT_ZERO) begin
                        cnt_next    = i_load_val;
                        reload_next = i_load_val;
                        flag_next   = i_auto_reload;
                        state_next  = RUN;
                    end else begin
                        // A zero-length countdown expires immediately
                        // without ever entering RUN.
                        cnt_next  = CNT_ZERO;
                        flag_next = 1'b0;
                        tc_next   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (i_abort) begin
                    // Abort outranks expiry, so no pulse is produced.
                    cnt_next   = CNT_ZERO;
                    state_next = IDLE;
                end else if (i_en && (cnt_reg == CNT_ONE)) begin
                    tc_next = 1'b1;
                    if (flag_reg) begin
                        cnt_next = reload_reg;
                    end else begin
                        cnt_next   = CNT_ZERO;
                        state_next = IDLE;
                    end
                end else if (i_en) begin
                    // In RUN the count is at least 1, so it cannot wrap.
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_load_ready = (state_reg == IDLE);
    assign o_busy       = (state_reg == RUN);
    assign o_cnt        = cnt_reg;
    assign o_tc         = tc_reg;

endmodule : countdown_timer

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter timer: the count-down counterpart to the team's free-running up-counter with terminal count. A producer loads a start value through a valid/ready handshake; the block decrements it on enabled cycles and emits a one-cycle terminal pulse at expiry. It either stops or reloads for periodic operation. It sits beside the up-counter as the programmable tick/timeout source for demo designs.

## Interface
- WIDTH, 8, bit width of the count and load value (≥2)
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_load_valid  input  1  load request
- o_load_ready  output  1  load can be accepted (high only in IDLE)
- i_load_val  input  WIDTH  start value N, sampled on handshake
- i_auto_reload  input  1  periodic mode, sampled on handshake
- i_en  input  1  decrement enable (RUN only)
- i_abort  input  1  cancel a running countdown
- o_cnt  output  WIDTH  current count (registered)
- o_busy  output  1  state == RUN
- o_tc  output  1  registered one-cycle expiry pulse

## Operation
- States: IDLE, RUN. Reset → IDLE, o_cnt=0, o_tc=0, reload register=0, reload flag=0.
- IDLE: o_load_ready=1. On i_load_valid & o_load_ready:
  - N≠0: o_cnt←N, reload reg←N, flag←i_auto_reload, → RUN.
  - N=0: o_cnt stays 0, o_tc=1 next cycle, stay IDLE, flag←0.
- RUN priority, highest first:
  - i_abort: o_cnt←0, → IDLE, no o_tc.
  - i_en & o_cnt==1: expiry, o_tc←1.
    - flag=1: o_cnt←reload reg, stay RUN.
    - flag=0: o_cnt←0, → IDLE.
  - i_en: o_cnt←o_cnt−1.
  - else: hold.
- i_load_valid in RUN is not accepted (ready=0). The producer must hold valid until ready. In IDLE, i_en and i_abort are ignored.
- Arithmetic is unsigned WIDTH bits. o_cnt never wraps below 0. Max N = 2^WIDTH−1.
- Periodic mode gives one o_tc per N enabled cycles, indefinitely, until abort.

## Timing
- Load at edge k: o_cnt=N and o_busy=1 after edge k. o_load_ready drops in the same cycle.
- With i_en held high, o_cnt reaches 1 after edge k+N−1. o_tc is high for the cycle after edge k+N. One-shot: o_busy=0 and o_load_ready=1 in that same cycle, so a new load is accepted at edge k+N+1 at the earliest.
- Periodic: o_tc is high after edges k+N, k+2N, …; o_cnt shows N in those cycles.
- o_tc is exactly one cycle wide. It is never high for two consecutive cycles unless N=1 in periodic mode, where it stays high every enabled cycle.
- Abort on the expiry cycle wins: no o_tc.
- Asynchronous reset mid-RUN forces all outputs to reset values immediately. A pending o_tc is dropped.
- Simultaneous valid and abort in IDLE: the load is accepted.

## Structure
- Package countdown_pkg: state enum typedef (IDLE, RUN).
- Single module, no sub-module. The FSM, count register, reload register/flag, and o_tc register all sit in one always_ff block with async reset. o_load_ready and o_busy are decoded from state.

## Test plan
- Reset, then one-shot load N=5 with i_en=1 → o_cnt 5,4,3,2,1,0; o_tc high for 1 cycle 5 edges after load; o_busy falls with o_tc.
- Periodic N=3, i_en=1 for 10 cycles → o_tc every 3rd cycle (3 pulses); o_cnt sequence 3,2,1,3,2,1,…
- Load N=4, toggle i_en 1,0,1,0,… → o_tc after 8 edges; o_cnt holds on i_en=0 cycles.
- Load N=6, assert i_abort when o_cnt=2 → o_cnt=0, IDLE, no o_tc; subsequent load N=2 completes normally.
- Load N=0 → o_tc single pulse next cycle, o_busy stays 0. Then load with valid high during RUN → ready=0 until expiry, accepted first IDLE cycle.
- Async reset pulse mid-countdown (N=200, WIDTH=8) → outputs 0 immediately, not after a clock edge; no o_tc after release.
